// File: rtl/serial_frame_rx_pkg.sv
// Shared frame-format definitions for the serial frame receiver:
// FSM state codes, default frame geometry and the synchronized pin bundle.
package serial_frame_rx_pkg;

    localparam int FRAME_W_DEF = 16;
    localparam int ADDR_W_DEF  = 4;

    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_SHIFT = 2'b01;
    localparam logic [1:0] ST_DONE  = 2'b10;

    typedef struct packed {
        logic clk;
        logic cs;
        logic da;
    } ser_pins_t;

    // Bus-idle pin levels: chip select deasserted, clock and data low.
    localparam ser_pins_t PINS_IDLE = '{clk: 1'b0, cs: 1'b1, da: 1'b0};

endpackage

// File: rtl/serial_frame_rx_sync_fifo.sv
// Small show-ahead synchronous FIFO; head entry is visible on o_rd_data whenever not empty.
module sync_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_rd_data,
    output logic             o_full,
    output logic             o_empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full    = (r_count == CW'(DEPTH));
    assign o_empty   = (r_count == '0);
    // A pop frees a slot in the same cycle, so a full FIFO still accepts a push alongside it.
    assign w_do_pop  = i_pop & ~o_empty;
    assign w_do_push = i_push & (~o_full | w_do_pop);
    assign o_rd_data = r_mem[r_rd_ptr];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // NOTE: storage has no reset; the pointers and count define which entries are valid.
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_wr_data;
    end

endmodule

// File: rtl/serial_frame_rx.sv
// Receiver for the cs/clk/data serial frame: synchronizes the pins, shifts in MSB-first
// frames, checks their length and queues good frames for a valid/ready consumer.
module serial_frame_rx
    import serial_frame_rx_pkg::*;
#(
    parameter int FRAME_W     = FRAME_W_DEF,
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int FIFO_DEPTH  = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      ser_clk,
    input  logic                      ser_cs,
    input  logic                      ser_da,
    input  logic                      out_ready,
    output logic                      out_valid,
    output logic [ADDR_W-1:0]         out_addr,
    output logic [FRAME_W-ADDR_W-1:0] out_data,
    output logic                      frame_err,
    output logic                      overflow,
    output logic                      busy,
    output logic [1:0]                state_o
);

    localparam int CNT_W   = $clog2(FRAME_W + 2);
    localparam int FLUSH   = SYNC_STAGES + 1;
    localparam int FLUSH_W = $clog2(FLUSH + 1);

    ser_pins_t          r_sync [SYNC_STAGES];
    logic               r_hist_clk;
    logic               r_hist_cs;
    logic [FLUSH_W-1:0] r_flush_cnt;

    logic [1:0]         r_state;
    logic [FRAME_W-1:0] r_shreg;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_frame_err;
    logic               r_overflow;

    ser_pins_t          w_pins;
    ser_pins_t          w_now;
    logic               w_flushed;
    logic               w_clk_rise;
    logic               w_cs_fall;
    logic               w_cs_rise;
    logic               w_push;
    logic               w_full;
    logic               w_empty;
    logic [FRAME_W-1:0] w_head;

    assign w_pins = '{clk: ser_clk, cs: ser_cs, da: ser_da};
    assign w_now  = r_sync[SYNC_STAGES-1];

    // NOTE: every flop here uses non-blocking assignment so all stages update from pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= PINS_IDLE;
            r_hist_clk  <= PINS_IDLE.clk;
            r_hist_cs   <= PINS_IDLE.cs;
            r_flush_cnt <= '0;
        end else begin
            r_sync[0] <= w_pins;
            for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
            r_hist_clk <= w_now.clk;
            r_hist_cs  <= w_now.cs;
            if (r_flush_cnt != FLUSH_W'(FLUSH)) r_flush_cnt <= r_flush_cnt + FLUSH_W'(1);
        end
    end

    // Until the chain and history flop hold real pin samples, the reset value cs=1 would fake a
    // cs_fall when cs is already low at release; that frame must wait for a genuine fall.
    assign w_flushed  = (r_flush_cnt == FLUSH_W'(FLUSH));
    assign w_clk_rise = w_now.clk & ~r_hist_clk;
    assign w_cs_fall  = ~w_now.cs & r_hist_cs & w_flushed;
    assign w_cs_rise  = w_now.cs & ~r_hist_cs;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= ST_IDLE;
            r_shreg     <= '0;
            r_cnt       <= '0;
            r_frame_err <= 1'b0;
        end else begin
            r_frame_err <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_cs_fall) begin
                        r_state <= ST_SHIFT;
                        r_shreg <= '0;
                        r_cnt   <= '0;
                    end
                end
                ST_SHIFT: begin
                    // A clock edge coinciding with cs_rise still contributes its bit.
                    if (w_clk_rise) begin
                        r_shreg <= {r_shreg[FRAME_W-2:0], w_now.da};
                        if (r_cnt != CNT_W'(FRAME_W + 1)) r_cnt <= r_cnt + CNT_W'(1);
                    end
                    if (w_cs_rise) r_state <= ST_DONE;
                end
                ST_DONE: begin
                    r_frame_err <= (r_cnt != CNT_W'(FRAME_W));
                    r_state     <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign w_push = (r_state == ST_DONE) && (r_cnt == CNT_W'(FRAME_W));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_overflow <= 1'b0;
        else      r_overflow <= w_push & w_full & ~out_ready;
    end

    sync_fifo #(
        .WIDTH (FRAME_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .i_push    (w_push),
        .i_wr_data (r_shreg),
        .i_pop     (out_ready),
        .o_rd_data (w_head),
        .o_full    (w_full),
        .o_empty   (w_empty)
    );

    // Head fields are forced to zero while empty so the outputs never expose stale storage.
    assign out_valid = ~w_empty;
    assign out_addr  = w_empty ? '0 : w_head[FRAME_W-1 -: ADDR_W];
    assign out_data  = w_empty ? '0 : w_head[FRAME_W-ADDR_W-1:0];
    assign frame_err = r_frame_err;
    assign overflow  = r_overflow;
    assign busy      = (r_state != ST_IDLE);
    assign state_o   = r_state;

endmodule

// File: tb/tb_serial_frame_rx.sv
// Scoreboard bench for serial_frame_rx: stimulus pushes expected frames, a negedge monitor
// pops and compares on every handshake and counts error/overflow pulses.
module tb_serial_frame_rx;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ser_clk = 1'b0;
    logic        ser_cs = 1'b1;
    logic        ser_da = 1'b0;
    logic        out_ready;
    logic        out_valid;
    logic [3:0]  out_addr;
    logic [11:0] out_data;
    logic        frame_err;
    logic        overflow;
    logic        busy;
    logic [1:0]  state_o;

    logic        ready_ctl = 1'b0;
    logic        rand_mode = 1'b0;
    logic        rand_ready = 1'b0;

    int          n_checks = 0;
    int          n_errors = 0;
    int          n_err_seen = 0;
    int          n_ovf_seen = 0;
    int          exp_err = 0;
    int          exp_ovf = 0;
    logic [15:0] sb [$];

    logic        hold_pending = 1'b0;
    logic [15:0] hold_val = '0;

    assign out_ready = rand_mode ? rand_ready : ready_ctl;

    serial_frame_rx dut (
        .clk       (clk),
        .rst       (rst),
        .ser_clk   (ser_clk),
        .ser_cs    (ser_cs),
        .ser_da    (ser_da),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_addr  (out_addr),
        .out_data  (out_data),
        .frame_err (frame_err),
        .overflow  (overflow),
        .busy      (busy),
        .state_o   (state_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            rand_ready = 1'($urandom_range(0, 1));
        end
    end

    // Monitor: samples on the falling edge, away from the DUT's active edge.
    initial begin
        logic [15:0] exp;
        forever begin
            @(negedge clk);
            if (!rst) begin
                hold_pending = 1'b0;
            end else begin
                if (frame_err) n_err_seen++;
                if (overflow)  n_ovf_seen++;
                if (hold_pending && out_valid)
                    check("hold_stable", {out_addr, out_data}, hold_val);
                hold_pending = out_valid && !out_ready;
                hold_val     = {out_addr, out_data};
                if (out_valid && out_ready) begin
                    if (sb.size() == 0) begin
                        n_checks++;
                        n_errors++;
                        $display("FAIL unexpected_frame: got 0x%0h expected none at %0t",
                                 {out_addr, out_data}, $time);
                    end else begin
                        exp = sb.pop_front();
                        check("out_addr", 32'(out_addr), 32'(exp[15:12]));
                        check("out_data", 32'(out_data), 32'(exp[11:0]));
                    end
                end
            end
        end
    end

    // Drives one cs-low period with nbits MSB-first bits at ser_clk = clk/4.
    // With skew set, cs rises together with the last clock rise; otherwise it returns right after cs rises.
    task automatic send_frame(input logic [31:0] val, input int nbits, input bit skew);
        ser_cs = 1'b0;
        repeat (4) tick();
        for (int i = nbits - 1; i >= 0; i--) begin
            ser_clk = 1'b0;
            ser_da  = val[i];
            repeat (2) tick();
            ser_clk = 1'b1;
            if (skew && i == 0) ser_cs = 1'b1;
            repeat (2) tick();
        end
        ser_clk = 1'b0;
        if (!skew) begin
            repeat (2) tick();
            ser_cs = 1'b1;
        end
    endtask

    // Reference model: a frame is good exactly when it carried 16 bits; a good frame is
    // queued if fewer than DEPTH frames are waiting, otherwise it is dropped with overflow.
    task automatic do_frame(input logic [31:0] val, input int nbits, input bit skew);
        send_frame(val, nbits, skew);
        if (nbits == 16) begin
            if (sb.size() < DEPTH) sb.push_back(val[15:0]);
            else                   exp_ovf++;
        end else begin
            exp_err++;
        end
        repeat (10) tick();
        check("frame_err_count", n_err_seen, exp_err);
        check("overflow_count", n_ovf_seen, exp_ovf);
        check("idle_after_frame", 32'(state_o), 32'(2'b00));
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while (sb.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        check("drain_pending", sb.size(), 0);
        tick();
        check("valid_after_drain", 32'(out_valid), 0);
    endtask

    task automatic check_reset_outputs();
        check("rst_state", 32'(state_o), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_valid", 32'(out_valid), 0);
        check("rst_addr", 32'(out_addr), 0);
        check("rst_data", 32'(out_data), 0);
        check("rst_frame_err", 32'(frame_err), 0);
        check("rst_overflow", 32'(overflow), 0);
    endtask

    initial begin
        logic [31:0] v;
        int          nb;

        // Reset state
        repeat (3) tick();
        check_reset_outputs();
        rst = 1'b1;
        repeat (5) tick();

        // 1: single good frame, consumer always ready
        ready_ctl = 1'b1;
        do_frame(32'hACF0, 16, 1'b0);
        wait_drain(50);

        // 2: short then long frame
        do_frame(32'h00007FFF, 15, 1'b0);
        do_frame(32'h0001ABCD, 17, 1'b0);
        check("valid_after_bad", 32'(out_valid), 0);

        // 3: fill the queue with the consumer stalled, fifth frame overflows
        ready_ctl = 1'b0;
        for (int k = 1; k <= 5; k++) do_frame(32'h1000 + 32'(k), 16, 1'b0);
        check("valid_when_full", 32'(out_valid), 1);
        ready_ctl = 1'b1;
        wait_drain(50);

        // 4: reset in mid-frame, released with cs still low
        v = 32'h0000C3C3;
        ser_cs = 1'b0;
        repeat (4) tick();
        for (int i = 15; i >= 8; i--) begin
            ser_clk = 1'b0; ser_da = v[i]; repeat (2) tick();
            ser_clk = 1'b1; repeat (2) tick();
        end
        rst = 1'b0;
        #1;
        check("midframe_rst_state", 32'(state_o), 0);
        check("midframe_rst_busy", 32'(busy), 0);
        repeat (3) tick();
        rst = 1'b1;
        for (int i = 7; i >= 0; i--) begin
            ser_clk = 1'b0; ser_da = v[i]; repeat (2) tick();
            ser_clk = 1'b1; repeat (2) tick();
        end
        ser_clk = 1'b0;
        repeat (2) tick();
        ser_cs = 1'b1;
        repeat (12) tick();
        check("orphan_frame_err", n_err_seen, exp_err);
        check("orphan_valid", 32'(out_valid), 0);
        check("orphan_state", 32'(state_o), 0);
        do_frame(32'h5A5A, 16, 1'b0);
        wait_drain(50);

        // 5: queue full, consumer ready only in the DONE cycle of the next frame
        ready_ctl = 1'b0;
        for (int k = 1; k <= 4; k++) do_frame(32'h3000 + 32'(k), 16, 1'b0);
        send_frame(32'h2222, 16, 1'b0);
        repeat (3) tick();
        check("done_state", 32'(state_o), 32'(2'b10));
        check("done_busy", 32'(busy), 1);
        ready_ctl = 1'b1;
        tick();
        ready_ctl = 1'b0;
        sb.push_back(16'h2222);
        repeat (8) tick();
        check("no_overflow_on_pop", n_ovf_seen, exp_ovf);
        check("still_full_valid", 32'(out_valid), 1);
        do_frame(32'h4444, 16, 1'b0);
        ready_ctl = 1'b1;
        wait_drain(50);

        // 6: cs rises together with the last clock rise
        do_frame(32'hBEEF, 16, 1'b1);
        wait_drain(50);

        // Random frames with a randomly stalling consumer
        rand_mode = 1'b1;
        for (int k = 0; k < 24; k++) begin
            v = $urandom;
            case ($urandom_range(0, 9))
                0:       nb = 15;
                1:       nb = 17;
                2:       nb = 18;
                default: nb = 16;
            endcase
            do_frame(v, nb, 1'($urandom_range(0, 1)));
        end
        rand_mode = 1'b0;
        ready_ctl = 1'b1;
        wait_drain(100);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
